fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage; requester side of instr_mem. Drives the fetch PC
//   and absorbs the memory's 1-cycle synchronous read latency. Delivers
//   {valid, pc, instr} to decode. Handles downstream stall (skid hold) and
//   branch/jump redirect (flush of the in-flight fetch).
// PARAMETERS
//   RESET_PC   32'h0000_0000  fetch address loaded on reset
//   MEM_DEPTH  1024           instr_mem depth in words; used by the bench/index check only
// PORTS
//   clk          in   1   single clock, all state on posedge
//   rst          in   1   synchronous, active-high reset
//   stall        in   1   decode cannot accept; hold current output
//   redirect     in   1   load redirect_pc, flush in-flight fetch
//   redirect_pc  in   32  redirect target; bits [1:0] ignored (forced 0)
//   imem_pc      out  32  address to instr_mem; sampled by memory at posedge
//   imem_instr   in   32  instr_mem data; equals mem[imem_pc of previous edge]
//   if_valid     out  1   if_pc/if_instr carry a real instruction
//   if_pc        out  32  address of if_instr
//   if_instr     out  32  instruction; INSTR_NOP (32'h0000_0013) when !if_valid
// BEHAVIOUR
//   Registers: fetch_pc (drives imem_pc directly), resp_pc, state, hold_instr.
//   States: EMPTY (no valid response), RUN (if_instr = imem_instr),
//     HOLD (if_instr = hold_instr). if_valid = (state != EMPTY).
//   Edge priority: rst > redirect > stall > advance.
//   rst: fetch_pc<=RESET_PC, resp_pc<=0, state<=EMPTY, hold_instr<=0.
//     Outputs after reset: imem_pc=RESET_PC, if_valid=0, if_pc=0, if_instr=NOP.
//   redirect: fetch_pc<={redirect_pc[31:2],2'b00}, state<=EMPTY. The in-flight
//     response is discarded. Target appears with if_valid=1 two cycles after
//     redirect is sampled (exactly one bubble).
//   stall & !redirect: fetch_pc, resp_pc held.
//     RUN->HOLD with hold_instr<=imem_instr.
//     HOLD->HOLD and EMPTY->EMPTY: no capture.
//   advance (!stall & !redirect): resp_pc<=fetch_pc, fetch_pc<=fetch_pc+4,
//     state<=RUN from any state.
//     Memory re-read fetch_pc during the stall, so data after release is correct.
//   Latency: 1 cycle from imem_pc to matching if_pc/if_instr; throughput 1 instr/cycle.
//   PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0000_0000. The memory
//     index wraps at MEM_DEPTH inside instr_mem; no check here.
//   Reset mid-HOLD or mid-redirect: reset wins outright; no residual valid.
//   No instruction is ever duplicated or skipped across stall/release.
//   redirect during HOLD drops the held instruction.
// STRUCTURE
//   rv32_pkg: XLEN=32, INSTR_NOP=32'h0000_0013, typedef enum logic [1:0]
//     fetch_state_t {FS_EMPTY, FS_RUN, FS_HOLD}.
//   Sub-module fetch_skid_reg (capture/select of hold_instr) is natural.
//     PC/state logic stays in fetch_unit.
//   Bench pairs fetch_unit with the real instr_mem; program.hex has mem[i]=32'hA000_0000+i.
// TESTING
//   1 Reset/run: rst=1 two cycles, then 0 -> 1st post-reset cycle if_valid=0,
//     imem_pc=0. Next cycles: if_pc=0,4,8 with if_instr=A000_0000,A000_0001,A000_0002.
//   2 Stall: assert stall 3 cycles while if_pc=0x8 -> if_pc=0x8, if_instr=A000_0002
//     all 3 cycles. Release -> 0xC/A000_0003 then 0x10/A000_0004; no gap or repeat.
//   3 Redirect: redirect=1, redirect_pc=0x40 -> next cycle if_valid=0,
//     then if_pc=0x40, if_instr=A000_0010, then 0x44/A000_0011.
//   4 Redirect+stall same cycle, redirect_pc=0x43 -> redirect wins; bubble, then
//     if_pc=0x40. Stall then honoured as normal (held at 0x40).
//   5 Wrap: redirect to 0xFFFF_FFFC -> if_pc=0xFFFF_FFFC (instr index 1023)
//     then 0x0000_0000/A000_0000.
//   6 Reset in HOLD: stall to HOLD, pulse rst -> next cycle if_valid=0,
//     if_instr=NOP, imem_pc=RESET_PC. Fetch restarts per scenario 1.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 constants and types for the fetch slice.
//   XLEN          datapath width
//   INSTR_NOP     canonical RV32I nop (addi x0, x0, 0) presented when no instruction is valid
//   MEM_DEPTH     instr_mem depth in words; the fetch unit itself never checks it
//   fetch_state_t response-side state of the fetch stage
package rv32_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int unsigned MEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        FS_EMPTY = 2'd0,  // no valid response this cycle
        FS_RUN   = 2'd1,  // response comes straight from instr_mem
        FS_HOLD  = 2'd2   // response replayed from the skid register
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// Skid register for the fetch stage: captures the memory response when decode stalls
// and selects which instruction is presented downstream.
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset
//   capture    load mem_instr into the hold register this edge
//   state      current fetch state, selects the output source
//   mem_instr  instr_mem read data
//   out_instr  instruction to decode; INSTR_NOP when state is FS_EMPTY
module fetch_skid_reg
    import rv32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  fetch_state_t      state,
    input  logic [XLEN-1:0]   mem_instr,
    output logic [XLEN-1:0]   out_instr
);

    logic [XLEN-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= mem_instr;
        end
    end

    always_comb begin
        out_instr = INSTR_NOP;
        unique case (state)
            FS_RUN:  out_instr = mem_instr;
            FS_HOLD: out_instr = hold_q;
            default: out_instr = INSTR_NOP;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage, requester side of a 1-cycle synchronous instr_mem.
// Drives the fetch PC, pairs each memory response with its address and hands
// {valid, pc, instr} to decode. Handles decode stall via a skid register and
// branch/jump redirect by flushing the in-flight fetch.
//   clk          clock, all state on posedge
//   rst          synchronous active-high reset
//   stall        decode cannot accept; hold current output
//   redirect     load redirect_pc and flush the in-flight fetch
//   redirect_pc  redirect target, low two bits ignored
//   imem_pc      address to instr_mem, sampled by the memory at posedge
//   imem_instr   instr_mem data for the address presented on the previous edge
//   if_valid     if_pc/if_instr carry a real instruction
//   if_pc        address of if_instr
//   if_instr     instruction; INSTR_NOP when if_valid is low
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [XLEN-1:0]   imem_pc,
    input  logic [XLEN-1:0]   imem_instr,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_pc,
    output logic [XLEN-1:0]   if_instr
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic            capture;

    // Word alignment is forced, so the low bits of the target are dropped.
    logic [1:0] unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc[1:0];

    // Priority: rst > redirect > stall > advance. While stalled, fetch_pc is held so the
    // memory keeps re-reading the next address and its data is current on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            state_q    <= FS_EMPTY;
        end else if (redirect) begin
            // The response arriving next cycle belongs to the old stream; drop it.
            fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
            state_q    <= FS_EMPTY;
        end else if (stall) begin
            if (state_q == FS_RUN) begin
                state_q <= FS_HOLD;
            end
        end else begin
            resp_pc_q  <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + 32'd4;
            state_q    <= FS_RUN;
        end
    end

    // Only a live memory response needs saving; HOLD already owns its copy.
    assign capture = !redirect && stall && (state_q == FS_RUN);

    fetch_skid_reg u_skid (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .state     (state_q),
        .mem_instr (imem_instr),
        .out_instr (if_instr)
    );

    assign imem_pc  = fetch_pc_q;
    assign if_pc    = resp_pc_q;
    assign if_valid = (state_q != FS_EMPTY);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 1-cycle synchronous instruction
// memory whose word i holds 32'hA000_0000 + i.
module tb_fetch_unit;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int vectors = 0;
    int errors  = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_pc     (imem_pc),
        .imem_instr  (imem_instr),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    always #5 clk = ~clk;

    // Memory model: index wraps at MEM_DEPTH words.
    always @(posedge clk) begin
        imem_instr <= 32'hA000_0000 + ((imem_pc >> 2) % MEM_DEPTH);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
        if (v) chk({tag, ".pc"}, if_pc, pc);
        chk({tag, ".instr"}, if_instr, instr);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // 1: reset and run
        step();
        step();
        rst = 1'b0;
        chk_out("rst", 1'b0, 32'h0, INSTR_NOP);
        chk("rst.if_pc", if_pc, 32'h0);
        chk("rst.imem_pc", imem_pc, 32'h0);
        step(); chk_out("run0", 1'b1, 32'h0, 32'hA000_0000);
        step(); chk_out("run1", 1'b1, 32'h4, 32'hA000_0001);
        step(); chk_out("run2", 1'b1, 32'h8, 32'hA000_0002);

        // 2: stall three cycles, then release with no gap or repeat
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_out("stall", 1'b1, 32'h8, 32'hA000_0002);
        end
        stall = 1'b0;
        step(); chk_out("rel0", 1'b1, 32'hC, 32'hA000_0003);
        step(); chk_out("rel1", 1'b1, 32'h10, 32'hA000_0004);

        // 3: redirect, exactly one bubble
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        chk_out("redir.bubble", 1'b0, 32'h0, INSTR_NOP);
        chk("redir.imem_pc", imem_pc, 32'h40);
        step(); chk_out("redir0", 1'b1, 32'h40, 32'hA000_0010);
        step(); chk_out("redir1", 1'b1, 32'h44, 32'hA000_0011);

        // 4: redirect beats stall, low target bits dropped; then a normal stall
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h43;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk_out("rs.bubble", 1'b0, 32'h0, INSTR_NOP);
        chk("rs.imem_pc", imem_pc, 32'h40);
        step(); chk_out("rs0", 1'b1, 32'h40, 32'hA000_0010);
        stall = 1'b1;
        step(); chk_out("rs.hold0", 1'b1, 32'h40, 32'hA000_0010);
        step(); chk_out("rs.hold1", 1'b1, 32'h40, 32'hA000_0010);
        stall = 1'b0;
        step(); chk_out("rs1", 1'b1, 32'h44, 32'hA000_0011);

        // 5: PC wraps modulo 2^32
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk_out("wrap.bubble", 1'b0, 32'h0, INSTR_NOP);
        step(); chk_out("wrap0", 1'b1, 32'hFFFF_FFFC, 32'hA000_03FF);
        chk("wrap.imem_pc", imem_pc, 32'h0);
        step(); chk_out("wrap1", 1'b1, 32'h0, 32'hA000_0000);

        // redirect while holding drops the held instruction
        stall = 1'b1;
        step(); chk_out("hr.hold", 1'b1, 32'h0, 32'hA000_0000);
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk_out("hr.bubble", 1'b0, 32'h0, INSTR_NOP);
        step(); chk_out("hr0", 1'b1, 32'h100, 32'hA000_0040);

        // 6: reset while in HOLD
        stall = 1'b1;
        step(); chk_out("rh.hold", 1'b1, 32'h100, 32'hA000_0040);
        rst = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0;
        chk_out("rh.rst", 1'b0, 32'h0, INSTR_NOP);
        chk("rh.if_pc", if_pc, 32'h0);
        chk("rh.imem_pc", imem_pc, 32'h0);
        step(); chk_out("rh0", 1'b1, 32'h0, 32'hA000_0000);
        step(); chk_out("rh1", 1'b1, 32'h4, 32'hA000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
